// File: rtl/cnn_window_gen.sv
// cnn_window_gen: raster-order sliding-window generator for one input channel.
// Emits every fully-inside KX x KY window (stride 1, no padding) one cycle
// after the pixel that completes it. Output packing is the kernel's
// flattened i_in_fmap bus: element ky*KX+kx sits at bits
// [(idx+1)*I_F_BW-1 : idx*I_F_BW], ky=0 top (oldest) row, kx=0 leftmost.
//
// Ports:
//   clk, reset_n       clock (rising edge), async active-low reset
//   i_soft_reset       synchronous clear of counters/outputs, drops input
//   i_in_valid         i_in_pixel accepted this cycle (no backpressure)
//   i_in_pixel         pixel, row 0 col 0 first
//   o_ot_valid         o_ot_window holds a new window
//   o_ot_window        KX*KY flattened window
//   o_ot_frame_done    pulse alongside the final window of a frame
//
// Assumes KX >= 2 and KY >= 2.

// One window row: KX-1 stored columns plus the incoming column pixel.
module cnn_win_row #(
  parameter int KX = 3,
  parameter int W  = 8
) (
  input  logic                   clk,
  input  logic                   i_shift,
  input  logic [W-1:0]           i_pix,
  output logic [KX-1:0][W-1:0]   o_row
);
  logic [KX-2:0][W-1:0] r_sh;

  // o_row is the window as it will look once i_pix is accepted.
  assign o_row = {i_pix, r_sh};

  always_ff @(posedge clk)
    if (i_shift) r_sh <= o_row[KX-1:1];
endmodule

module cnn_window_gen #(
  parameter int KX     = 3,
  parameter int KY     = 3,
  parameter int I_F_BW = 8,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_soft_reset,
  input  logic                       i_in_valid,
  input  logic [I_F_BW-1:0]          i_in_pixel,
  output logic                       o_ot_valid,
  output logic [KX*KY*I_F_BW-1:0]    o_ot_window,
  output logic                       o_ot_frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [CW-1:0]                          r_col;
  logic [RW-1:0]                          r_row;
  logic [I_F_BW-1:0]                      r_lb [KY-1][IMG_W];
  logic                                   r_ot_valid;
  logic                                   r_ot_frame_done;
  logic [KY-1:0][KX-1:0][I_F_BW-1:0]      r_window;

  logic                                   w_accept;
  logic                                   w_last_col;
  logic                                   w_last_row;
  logic                                   w_hit;
  logic [KY-1:0][I_F_BW-1:0]              w_col;
  logic [KY-1:0][KX-1:0][I_F_BW-1:0]      w_win;

  assign w_accept   = i_in_valid & ~i_soft_reset;
  assign w_last_col = (r_col == CW'(IMG_W-1));
  assign w_last_row = (r_row == RW'(IMG_H-1));
  assign w_hit      = w_accept && (r_row >= RW'(KY-1)) && (r_col >= CW'(KX-1));

  // New column, top to bottom: oldest line buffer first, live pixel last.
  genvar ky;
  generate
    for (ky = 0; ky < KY; ky++) begin : g_row
      if (ky < KY-1) begin : g_lb
        assign w_col[ky] = r_lb[KY-2-ky][r_col];
      end else begin : g_live
        assign w_col[ky] = i_in_pixel;
      end
      cnn_win_row #(.KX(KX), .W(I_F_BW)) u_row (
        .clk     (clk),
        .i_shift (w_accept),
        .i_pix   (w_col[ky]),
        .o_row   (w_win[ky])
      );
    end
  endgenerate

  // Line buffers cascade at the current column: lb[0] is the previous row.
  // Reads above see the pre-write contents.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][r_col] <= i_in_pixel;
      for (int k = 1; k < KY-1; k++)
        r_lb[k][r_col] <= r_lb[k-1][r_col];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col           <= '0;
      r_row           <= '0;
      r_ot_valid      <= 1'b0;
      r_ot_frame_done <= 1'b0;
      r_window        <= '0;
    end else if (i_soft_reset) begin
      r_col           <= '0;
      r_row           <= '0;
      r_ot_valid      <= 1'b0;
      r_ot_frame_done <= 1'b0;
      r_window        <= '0;
    end else begin
      r_ot_valid      <= w_hit;
      r_ot_frame_done <= w_accept && w_last_col && w_last_row;
      if (w_hit) r_window <= w_win;
      if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_ot_valid      = r_ot_valid;
  assign o_ot_window     = r_window;
  assign o_ot_frame_done = r_ot_frame_done;
endmodule

// File: tb/tb_cnn_window_gen.sv
// Bench for cnn_window_gen (3x3 window, 8x8 image, 8-bit pixels).
// A pixel-array model predicts each window when its completing pixel is
// driven; the prediction is queued and compared when the DUT emits it.
module tb_cnn_window_gen;
  localparam int WB = 72;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_soft_reset;
  logic          i_in_valid;
  logic [7:0]    i_in_pixel;
  logic          o_ot_valid;
  logic [WB-1:0] o_ot_window;
  logic          o_ot_frame_done;

  cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(8), .IMG_W(8), .IMG_H(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_soft_reset    (i_soft_reset),
    .i_in_valid      (i_in_valid),
    .i_in_pixel      (i_in_pixel),
    .o_ot_valid      (o_ot_valid),
    .o_ot_window     (o_ot_window),
    .o_ot_frame_done (o_ot_frame_done)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            fd_cnt  = 0;
  logic [7:0]    m_img [8][8];
  int            m_r = 0, m_c = 0;
  bit            pend_v = 0, pend_fd = 0;
  logic [WB-1:0] q[$];
  logic [WB-1:0] got[$];

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WB-1:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  // Compare what the previous clock edge produced against the predictions.
  task automatic observe();
    logic [WB-1:0] e;
    chk("valid", WB'(o_ot_valid), WB'(pend_v));
    chk("frame_done", WB'(o_ot_frame_done), WB'(pend_fd));
    if (o_ot_valid) begin
      chk("sb_nonempty", WB'(q.size() != 0), WB'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("window", o_ot_window, e);
      end
      got.push_back(o_ot_window);
    end
    if (o_ot_frame_done) fd_cnt++;
  endtask

  task automatic step(input bit v, input logic [7:0] px, input bit sr);
    logic [WB-1:0] w;
    @(negedge clk);
    observe();
    i_in_valid   = v;
    i_in_pixel   = px;
    i_soft_reset = sr;
    pend_v  = 0;
    pend_fd = 0;
    if (sr) begin
      m_r = 0; m_c = 0;
    end else if (v) begin
      m_img[m_r][m_c] = px;
      if (m_r >= 2 && m_c >= 2) begin
        w = '0;
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++)
            w[(ky*3+kx)*8 +: 8] = m_img[m_r-2+ky][m_c-2+kx];
        q.push_back(w);
        pend_v = 1;
      end
      if (m_r == 7 && m_c == 7) pend_fd = 1;
      if (m_c == 7) begin
        m_c = 0;
        m_r = (m_r == 7) ? 0 : m_r + 1;
      end else m_c++;
    end
  endtask

  task automatic frame(input bit inv, input int gap_pct);
    for (int p = 0; p < 64; p++) begin
      for (int g = 0; g < 4 && $urandom_range(99) < gap_pct; g++)
        step(1'b0, 8'h5A, 1'b0);
      step(1'b1, inv ? 8'(255 - p) : 8'(p), 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; i_soft_reset = 1'b0; i_in_valid = 1'b0; i_in_pixel = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", WB'(o_ot_valid), WB'(0));
    chk("rst_window", o_ot_window, '0);
    chk("rst_frame_done", WB'(o_ot_frame_done), WB'(0));
    reset_n = 1'b1;

    // Continuous full frame.
    got.delete(); fd_cnt = 0;
    frame(1'b0, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("f1_count", WB'(got.size()), WB'(36));
    if (got.size() == 36) begin
      chk("f1_first", got[0],  pk(0, 1, 2, 8, 9, 10, 16, 17, 18));
      chk("f1_row2_end", got[5], pk(5, 6, 7, 13, 14, 15, 21, 22, 23));
      chk("f1_row3_start", got[6], pk(8, 9, 10, 16, 17, 18, 24, 25, 26));
      chk("f1_last", got[35], pk(45, 46, 47, 53, 54, 55, 61, 62, 63));
    end
    chk("f1_fd_cnt", WB'(fd_cnt), WB'(1));

    // Same frame with random input gaps.
    got.delete();
    frame(1'b0, 50);
    step(1'b0, 8'h00, 1'b0);
    chk("gap_count", WB'(got.size()), WB'(36));
    if (got.size() == 36) begin
      chk("gap_first", got[0],  pk(0, 1, 2, 8, 9, 10, 16, 17, 18));
      chk("gap_last", got[35], pk(45, 46, 47, 53, 54, 55, 61, 62, 63));
    end

    // Back-to-back frames, second inverted.
    got.delete(); fd_cnt = 0;
    frame(1'b0, 0);
    frame(1'b1, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("b2b_count", WB'(got.size()), WB'(72));
    if (got.size() == 72)
      chk("b2b_f2_first", got[36], pk(255, 254, 253, 247, 246, 245, 239, 238, 237));
    chk("b2b_fd_cnt", WB'(fd_cnt), WB'(2));

    // Soft reset after pixel 30 (the pixel offered with it is dropped).
    for (int p = 0; p <= 30; p++) step(1'b1, 8'(p), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    got.delete();
    frame(1'b0, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("srst_count", WB'(got.size()), WB'(36));
    if (got.size() == 36) begin
      chk("srst_first", got[0],  pk(0, 1, 2, 8, 9, 10, 16, 17, 18));
      chk("srst_last", got[35], pk(45, 46, 47, 53, 54, 55, 61, 62, 63));
    end

    // Async reset while a window is being presented.
    for (int p = 0; p <= 18; p++) step(1'b1, 8'(p), 1'b0);
    @(posedge clk); #2;
    chk("ar_pre_valid", WB'(o_ot_valid), WB'(1));
    i_in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", WB'(o_ot_valid), WB'(0));
    chk("ar_window", o_ot_window, '0);
    chk("ar_frame_done", WB'(o_ot_frame_done), WB'(0));
    q.delete(); pend_v = 0; pend_fd = 0; m_r = 0; m_c = 0;
    @(negedge clk);
    reset_n = 1'b1;
    got.delete();
    frame(1'b0, 0);
    step(1'b0, 8'h00, 1'b0);
    chk("ar_count", WB'(got.size()), WB'(36));
    if (got.size() == 36)
      chk("ar_first", got[0], pk(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk("sb_drained", WB'(q.size()), WB'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Sliding-window generator that sits directly upstream of the per-channel convolution kernel.
- Accepts a raster-order pixel stream for one input channel and emits every fully-inside KX x KY window; stride 1, no padding ("valid" convolution).
- Output packing matches the kernel's flattened i_in_fmap bus, so o_ot_valid/o_ot_window connect straight to its i_in_valid/i_in_fmap.

Parameters:
- KX, 3, kernel width.
- KY, 3, kernel height.
- I_F_BW, 8, bit width of one input feature (pixel).
- IMG_W, 8, image width in pixels (must be >= KX).
- IMG_H, 8, image height in pixels (must be >= KY).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_soft_reset  input  1  synchronous clear; priority over all other inputs.
- i_in_valid  input  1  i_in_pixel is valid this cycle (accepted unconditionally, no ready).
- i_in_pixel  input  I_F_BW  pixel, raster order: row 0 col 0 first.
- o_ot_valid  output  1  o_ot_window holds a new complete window.
- o_ot_window  output  KX*KY*I_F_BW  window; element idx = ky*KX+kx at bits [(idx+1)*I_F_BW-1 : idx*I_F_BW]. ky=0 is the top (oldest) row, kx=0 is the leftmost column.
- o_ot_frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (reset_n low, async): o_ot_valid=0, o_ot_window=0, o_ot_frame_done=0, col/row counters=0.
- Soft reset (i_soft_reset=1 at a clock edge): same clears applied synchronously. Any i_in_valid in that cycle is dropped. Line-buffer and shift-register contents are left as-is (don't care, since output is gated by counters).
- Storage:
  - KY-1 line buffers of IMG_W x I_F_BW, holding the previous KY-1 rows.
  - A KY x KX register window that shifts left by one column on each accepted pixel.
  - New column = {line_buf[KY-2][col] .. line_buf[0][col], i_in_pixel}, top to bottom.
  - Line buffers update at [col] in the same cycle (read-before-write).
- Counters: col advances 0..IMG_W-1 on each accepted pixel. At col=IMG_W-1 it wraps to 0 and row increments. At row=IMG_H-1, col=IMG_W-1, both wrap to 0 and the next frame starts with no dead cycle.
- Output valid: an accepted pixel at (row,col) with row>=KY-1 and col>=KX-1 completes a window. o_ot_valid=1 on the next cycle (latency 1), with o_ot_window registered in that cycle. Otherwise o_ot_valid=0.
- Windows never straddle rows. Columns 0..KX-2 of each row produce no output, although the shift register still loads them.
- o_ot_window holds its last value while o_ot_valid=0.
- Windows per frame = (IMG_W-KX+1)*(IMG_H-KY+1), i.e. 36 for the defaults.
- o_ot_frame_done asserts in the same cycle as the final window's o_ot_valid.
- Input gaps (i_in_valid=0): all state holds and no output is produced. Any gap pattern yields identical window contents.
- Back-to-back frames: the first KY-1 rows of a new frame overwrite the line buffers before any window of that frame is emitted. Stale data from the old frame never appears in an output.
- No arithmetic. Widths are pass-through.

Test Plan:
- Full frame, continuous valid, pixel=row*8+col (0..63): first o_ot_valid comes 1 cycle after pixel 18, window idx0..8 = 0,1,2,8,9,10,16,17,18. Last window = 45,46,47,53,54,55,61,62,63, with o_ot_frame_done=1 in the same cycle. Exactly 36 valid pulses.
- Same frame with random i_in_valid gaps (~50% duty): the 36 windows are identical, in the same order. Each o_ot_valid comes exactly 1 cycle after its completing pixel.
- Row boundary: windows ending at col 7 row 2 = {5,6,7,13,14,15,21,22,23}. No valid after pixels 24 and 25 (col 0/1); the next valid follows pixel 26 = {8,9,10,16,17,18,24,25,26}.
- Two back-to-back frames, second frame pixel=255-(row*8+col): second frame's first window = 255,254,253,247,246,245,239,238,237. No window mixes data from the two frames. Two frame_done pulses.
- i_soft_reset asserted mid-frame (after pixel 30), then a fresh frame: no output during or after the soft reset until the new pixel 18. Windows then match the first scenario.
- reset_n asserted while o_ot_valid=1: o_ot_valid, o_ot_window and o_ot_frame_done drop to 0 immediately (async). After release the block restarts at row 0 col 0.
